// File: rtl/keccak_arbiter.sv
// Session-level two-requester arbiter in front of a shared keccak_sponge.
// Options: KECCAK_ARB_FIXED_PRIO_EN (requester 0 always wins), KECCAK_ARB_WDOG_EN (drain watchdog).
module keccak_arbiter #(
   parameter int WDOG_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   input  logic [3:0]  r_mode,
   input  logic [1:0]  r_start,
   input  logic [1:0]  r_absorb_valid,
   input  logic [1:0]  r_absorb_last,
   input  logic [15:0] r_absorb_data,
   output logic [1:0]  r_absorb_ready,
   output logic [1:0]  r_squeeze_valid,
   input  logic [1:0]  r_squeeze_ready,
   output logic [7:0]  r_squeeze_data,
   output logic [1:0]  k_mode,
   output logic        k_start,
   output logic        k_absorb_valid,
   output logic        k_absorb_last,
   output logic [7:0]  k_absorb_data,
   input  logic        k_absorb_ready,
   input  logic [7:0]  k_squeeze_data,
   input  logic        k_squeeze_valid,
   output logic        k_squeeze_ready,
   input  logic        k_busy,
   output logic        wdog_err
);

   typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

   state_t     state;
   logic       owner;
   logic [1:0] last_mode;
   logic       pick;
   logic       wdog_fire;

`ifdef KECCAK_ARB_FIXED_PRIO_EN
   assign pick = ~req[0];
`else
   logic rr_ptr;

   assign pick = (req == 2'b11) ? rr_ptr : req[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (state == OWN && !req[owner]) begin
         rr_ptr <= ~owner;
      end
   end
`endif

`ifdef KECCAK_ARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES + 1);
   logic [CW-1:0] wdog_cnt;

   // Fires on the WDOG_CYCLES-th consecutive busy DRAIN cycle.
   assign wdog_fire = (state == DRAIN) && k_busy && (wdog_cnt == CW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         if (state == DRAIN && k_busy && !wdog_fire) wdog_cnt <= wdog_cnt + 1'b1;
         else                                        wdog_cnt <= '0;
         if (wdog_fire) wdog_err <= 1'b1;
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_fire   = 1'b0;
   assign wdog_err    = 1'b0;
`endif

   // NOTE: async active-low reset; every register, including last_mode, has a defined reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         gnt       <= 2'b00;
         last_mode <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  owner <= pick;
                  gnt   <= pick ? 2'b10 : 2'b01;
                  state <= OWN;
               end
            end
            OWN: begin
               last_mode <= r_mode[{owner, 1'b0} +: 2];
               if (!req[owner]) begin
                  gnt   <= 2'b00;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!k_busy || wdog_fire) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      k_mode          = 2'b00;
      k_start         = 1'b0;
      k_absorb_valid  = 1'b0;
      k_absorb_last   = 1'b0;
      k_absorb_data   = 8'h00;
      k_squeeze_ready = 1'b0;
      r_absorb_ready  = 2'b00;
      r_squeeze_valid = 2'b00;
      case (state)
         OWN: begin
            k_mode                 = r_mode[{owner, 1'b0} +: 2];
            k_start                = r_start[owner];
            k_absorb_valid         = r_absorb_valid[owner];
            k_absorb_last          = r_absorb_last[owner];
            k_absorb_data          = r_absorb_data[{owner, 3'b000} +: 8];
            k_squeeze_ready        = r_squeeze_ready[owner];
            r_absorb_ready[owner]  = k_absorb_ready;
            r_squeeze_valid[owner] = k_squeeze_valid;
         end
         DRAIN: begin
            // Swallow any stray squeeze bytes while the sponge finishes.
            k_mode          = last_mode;
            k_squeeze_ready = 1'b1;
         end
         default: ;
      endcase
   end

   assign r_squeeze_data = k_squeeze_data;

endmodule

// File: doc/keccak_arbiter.md
# keccak_arbiter

Two-requester arbiter that shares a single `keccak_sponge` between independent sequencers, for example `auto_encaps_ctrl` and a decaps or host-side hashing controller. A grant covers a whole session, from first `start` to release, so absorb and squeeze streams are never interleaved. The arbiter sits between the requesters' Keccak-facing signals and the sponge's `mode/start/absorb_*/squeeze_*` ports.

## Interface
Parameters:
- `WDOG_CYCLES`, default 4096: drain watchdog limit. Used only when `KECCAK_ARB_WDOG_EN` is defined.

Ports. Requester vectors are indexed by requester number; byte lanes are `[8*i+7:8*i]`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: level request; held high for the whole session.
- `gnt` out 2: one-hot-or-zero grant.
- `r_mode` in 4: per-requester 2-bit sponge mode.
- `r_start` in 2: per-requester sponge start.
- `r_absorb_valid` in 2: per-requester absorb valid.
- `r_absorb_last` in 2: per-requester absorb last.
- `r_absorb_data` in 16: per-requester absorb byte.
- `r_absorb_ready` out 2: per-requester absorb ready.
- `r_squeeze_valid` out 2: per-requester squeeze valid.
- `r_squeeze_ready` in 2: per-requester squeeze ready.
- `r_squeeze_data` out 8: squeeze byte, broadcast to both requesters.
- `k_mode` out 2, `k_start` out 1: to the sponge.
- `k_absorb_valid`, `k_absorb_last` out 1 each; `k_absorb_data` out 8: to the sponge.
- `k_absorb_ready` in 1: from the sponge.
- `k_squeeze_data` in 8, `k_squeeze_valid` in 1: from the sponge.
- `k_squeeze_ready` out 1: to the sponge.
- `k_busy` in 1: sponge busy.
- `wdog_err` out 1: sticky drain-timeout flag. Tied 0 when `KECCAK_ARB_WDOG_EN` is not defined.

## Operation
- FSM states: IDLE, OWN, DRAIN. Registers: `owner` (1 bit), `rr_ptr` (1 bit), `gnt` (2 bits).
- IDLE, no request: stay in IDLE.
- IDLE, one requester high: grant it and go to OWN.
- IDLE, both high, round-robin build: grant requester `rr_ptr`.
- OWN: `gnt[owner]`=1.
  - All `k_*` outputs are muxed combinationally from `r_*[owner]`.
  - `r_absorb_ready[owner]`=`k_absorb_ready`; `r_squeeze_valid[owner]`=`k_squeeze_valid`.
  - Non-owner sees `r_absorb_ready`=0 and `r_squeeze_valid`=0. Its `start`, `absorb_valid` and `squeeze_ready` are ignored.
  - `r_squeeze_data`=`k_squeeze_data` unconditionally. Only `r_squeeze_valid` qualifies it.
- OWN → DRAIN when `req[owner]` falls. `gnt` clears on that same clock edge, and `rr_ptr` ← `~owner`.
- Protocol rule: a requester drops `req` only after its last squeeze byte is accepted.
- DRAIN outputs:
  - `k_start`=0, `k_absorb_valid`=0, `k_squeeze_ready`=1, which discards any stray squeeze bytes.
  - `k_mode` holds the last owner's mode.
- DRAIN → IDLE when `k_busy`=0, sampled on the clock edge.
- IDLE and DRAIN outputs: all `r_absorb_ready`/`r_squeeze_valid`=0. In IDLE, `k_start`/`k_absorb_valid`/`k_absorb_last`/`k_squeeze_ready`=0 and `k_mode`=0.
- A `req` that rises during OWN or DRAIN waits. There is no preemption.
- The owner may issue multiple `r_start` pulses within one session (e.g. SHA3 then SHAKE). The arbiter does not count them.

## Timing
- Reset values: `gnt`=0, `owner`=0, `rr_ptr`=0, state IDLE, `wdog_err`=0, all `k_*` and `r_*` outputs 0.
- Reset is asynchronous and may assert mid-session. All outputs drop immediately. The sponge must be reset by the same `rst_n`.
- Grant latency:
  - `req` high in IDLE at edge N → `gnt` high after edge N+1.
  - The requester may assert `r_start` in the first cycle `gnt` is seen.
- Release gap:
  - `req` low at edge N → DRAIN from N+1.
  - The earliest next grant is 2 edges after `k_busy` is seen low: one edge for DRAIN → IDLE, one edge for IDLE → OWN.
- Data paths are zero-latency combinational muxes. There is no buffering, and handshake semantics pass through unchanged.
- Simultaneous requests immediately after reset: requester 0 wins. After that, the winner alternates.
- The current owner re-raising `req` in the cycle it is released goes through arbitration like any other request.

## Configuration
- `KECCAK_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 always wins simultaneous requests.
  - `rr_ptr` is not implemented.
  - Use this when encaps must never wait behind a background hasher.
- `KECCAK_ARB_FIXED_PRIO_EN` undefined: round-robin as described in Operation.
- `WDOG_CYCLES` and `wdog_err` belong to the separate `KECCAK_ARB_WDOG_EN` option and are unaffected by `KECCAK_ARB_FIXED_PRIO_EN`.

## Test plan
- Reset, then `req`=01 at edge 5 → `gnt`=01 after edge 6. A 32-byte SHA3-256 absorb/squeeze through requester 0 matches the reference digest, and requester 1 sees `r_squeeze_valid`=0 throughout.
- `req`=11 asserted together twice in a row, each session ending with `k_busy` low → first grant 01, second grant 10. With `KECCAK_ARB_FIXED_PRIO_EN`, both grants are 01.
- Requester 1 raises `req` mid-session of requester 0 and pulses `r_start`/`r_absorb_valid` → `k_start` and `k_absorb_valid` stay owner-driven, and requester 1 is granted exactly 2 edges after `k_busy` falls.
- Owner drops `req` with `k_squeeze_valid` high and `k_busy` high for 3 more cycles → `k_squeeze_ready`=1 for those 3 cycles, `gnt`=00, and IDLE is reached on the edge where `k_busy`=0.
- With `KECCAK_ARB_WDOG_EN`, `WDOG_CYCLES`=16, and `k_busy` stuck high in DRAIN → `wdog_err` rises at the 16th DRAIN cycle, the FSM enters IDLE, and `wdog_err` stays high until reset.
- `rst_n` pulsed low mid-absorb → `gnt`, `k_start`, `k_absorb_valid` and `r_absorb_ready` are 0 within the same cycle. After release, a fresh session produces the correct digest.
